// File: rtl/microcode_patch_store.sv
// Associative microcode patch overlay answering fetches beside microcode_rom.
// Optional per-slot parity checking is enabled by defining MCPATCH_PARITY_EN.
module microcode_patch_store #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              enable,
    output logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              hit,
    output logic              error,
    input  logic              ld_valid,
    input  logic              ld_clear,
    input  logic [IDX_W-1:0]  ld_index,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_par_inv,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] last_addr,
    output logic [15:0]       access_count,
    output logic [15:0]       hit_count
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        LOOKUP = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t             state, state_n;
    logic [IDX_W-1:0]   init_idx;
    logic               lk_phase;

    logic [ENTRIES-1:0] valid;
    logic [ADDR_W-1:0]  slot_addr [ENTRIES];
    logic [DATA_W-1:0]  slot_data [ENTRIES];

    logic               fetch_acc;
    logic               lk_first;
    logic               lk_done;
    logic               resp_exit;
    logic               ld_accept;

    logic               lk_hit;
    logic [IDX_W-1:0]   lk_idx;
    logic               lk_perr;

    logic [ADDR_W-1:0]  addr_p0;
    logic [DATA_W-1:0]  data_p1;
    logic               hit_p1;
    logic               err_p1;

    always_comb begin
        state_n   = state;
        fetch_acc = 1'b0;
        lk_first  = 1'b0;
        lk_done   = 1'b0;
        resp_exit = 1'b0;
        case (state)
            INIT: begin
                if (init_idx == LAST_IDX) state_n = IDLE;
            end
            IDLE: begin
                if (enable) begin
                    state_n   = LOOKUP;
                    fetch_acc = 1'b1;
                end
            end
            LOOKUP: begin
                if (lk_phase) begin
                    state_n = RESP;
                    lk_done = 1'b1;
                end else begin
                    lk_first = 1'b1;
                end
            end
            RESP: begin
                if (!enable) begin
                    state_n   = IDLE;
                    resp_exit = 1'b1;
                end
            end
            default: state_n = INIT;
        endcase
    end

    assign ld_accept = ld_valid && (state != INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_idx <= '0;
            lk_phase <= 1'b0;
        end else begin
            state    <= state_n;
            init_idx <= (state == INIT) ? init_idx + 1'b1 : '0;
            lk_phase <= lk_first;
        end
    end

    // Valid bits: bulk clear on reset, walked clear in INIT, then load port.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (state == INIT) begin
            valid[init_idx] <= 1'b0;
        end else if (ld_valid) begin
            valid[ld_index] <= !ld_clear;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_accept && !ld_clear) begin
            slot_addr[ld_index] <= ld_addr;
            slot_data[ld_index] <= ld_data;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (slot_addr[i] == addr_p0)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

`ifdef MCPATCH_PARITY_EN
    function automatic logic even_par(input logic [ADDR_W-1:0] a,
                                      input logic [DATA_W-1:0] d);
        return ^{a, d};
    endfunction

    logic slot_par [ENTRIES];

    always_ff @(posedge clk) begin
        if (ld_accept && !ld_clear) begin
            slot_par[ld_index] <= even_par(ld_addr, ld_data) ^ ld_par_inv;
        end
    end

    assign lk_perr = lk_hit &&
                     (even_par(slot_addr[lk_idx], slot_data[lk_idx]) != slot_par[lk_idx]);
`else
    logic unused_par_inv;
    assign unused_par_inv = ld_par_inv;
    assign lk_perr        = 1'b0;
`endif

    // p0: fetch address captured at acceptance
    always_ff @(posedge clk) begin
        if (fetch_acc) addr_p0 <= addr;
    end

    // p1: compare result against the table as it stood before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (lk_first) begin
            hit_p1 <= lk_hit && !lk_perr;
            err_p1 <= lk_perr;
        end
    end

    always_ff @(posedge clk) begin
        if (lk_first) data_p1 <= (lk_hit && !lk_perr) ? slot_data[lk_idx] : '0;
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ready        <= 1'b0;
            ld_ready     <= 1'b0;
            data         <= '0;
            hit          <= 1'b0;
            error        <= 1'b0;
            last_addr    <= '0;
            access_count <= '0;
            hit_count    <= '0;
        end else begin
            ready    <= (state_n == IDLE) || (state_n == RESP);
            ld_ready <= (state_n != INIT);
            if (fetch_acc) begin
                last_addr    <= addr;
                access_count <= sat_inc(access_count);
            end
            if (lk_done) begin
                data  <= data_p1;
                hit   <= hit_p1;
                error <= err_p1;
                if (hit_p1) hit_count <= sat_inc(hit_count);
            end
            if (resp_exit) begin
                data  <= '0;
                hit   <= 1'b0;
                error <= 1'b0;
            end
        end
    end

endmodule
